// File: rtl/knn_pkg.sv
// Shared types and constants for the KNN distance engine and its lanes.
package knn_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    typedef enum logic {
        MODE_SQ_EUCLID = 1'b0,
        MODE_MANHATTAN = 1'b1
    } mode_e;

    // Wide enough for any practical DW; the top slices off what it needs.
    localparam int MAX_DW = 128;
    localparam logic [MAX_DW-1:0] DIST_RESET = '1;

    // Accumulator width that can never overflow for an M x N sample of W-bit features.
    function automatic int default_dw(input int m, input int n, input int w);
        return 2 * w + 2 + $clog2(m * n);
    endfunction

endpackage

// File: rtl/distance_lane.sv
// One feature lane: registered signed difference, then registered square or magnitude.
module distance_lane
    import knn_pkg::*;
#(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [W-1:0]   in_feat,
    input  logic [W-1:0]   tr_feat,
    input  mode_e          mode,
    output logic [2*W+1:0] mag
);

    logic signed [W:0]     diff_r;
    logic signed [2*W+1:0] diff_x_s;
    logic [2*W+1:0]        square_s;
    logic [W:0]            abs_s;
    logic [2*W+1:0]        mag_next_s;
    logic [2*W+1:0]        mag_r;

    // Stage 1: difference of the sign-extended features.
    always_ff @(posedge clk) begin
        if (rst) begin
            diff_r <= '0;
        end else begin
            diff_r <= $signed({in_feat[W-1], in_feat}) - $signed({tr_feat[W-1], tr_feat});
        end
    end

    // Square and magnitude of the stage-1 difference; mode picks one.
    always_comb begin
        diff_x_s = {{(W+1){diff_r[W]}}, diff_r};
        square_s = $unsigned(diff_x_s * diff_x_s);
        if (diff_r[W]) begin
            abs_s = $unsigned(-diff_r);
        end else begin
            abs_s = $unsigned(diff_r);
        end
        if (mode == MODE_MANHATTAN) begin
            mag_next_s = {{(W+1){1'b0}}, abs_s};
        end else begin
            mag_next_s = square_s;
        end
    end

    // Stage 2 register.
    always_ff @(posedge clk) begin
        if (rst) begin
            mag_r <= '0;
        end else begin
            mag_r <= mag_next_s;
        end
    end

    assign mag = mag_r;

endmodule

// File: rtl/knn_distance_engine.sv
// Lane-parallel squared-Euclidean / Manhattan distance between a query and a training sample.
module knn_distance_engine
    import knn_pkg::*;
#(
    parameter int M     = 4,
    parameter int N     = 4,
    parameter int W     = 8,
    parameter int LANES = 2,
    parameter int DW    = default_dw(M, N, W)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          mode,
    input  logic [W-1:0]  training_data [0:M*N-1],
    input  logic [W-1:0]  training_data_type,
    input  logic [W-1:0]  input_data [0:M*N-1],
    output logic          busy,
    output logic [DW-1:0] distance,
    output logic [W-1:0]  data_type,
    output logic          saturated,
    output logic          done
);

    localparam int FEATS = M * N;
    localparam int BEATS = FEATS / LANES;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int IW    = (FEATS > 1) ? $clog2(FEATS) : 1;
    localparam int LW    = 2 * W + 2;
    localparam int SW    = LW + $clog2(LANES) + 1;
    localparam int XW    = ((DW > SW) ? DW : SW) + 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
    localparam logic [DW-1:0] DIST_MAX  = DIST_RESET[DW-1:0];

    if ((FEATS % LANES) != 0) begin : g_lanes_check
        $error("knn_distance_engine: LANES must divide M*N");
    end

    state_e         state_r;
    state_e         state_next_s;
    logic [BW-1:0]  beat_r;
    logic           drain_r;
    mode_e          mode_r;
    logic [W-1:0]   label_r;
    logic           v1_r;
    logic           v2_r;
    logic [DW-1:0]  acc_r;
    logic           sticky_r;
    logic           accept_s;
    logic           issue_s;
    logic           finish_s;
    logic [IW-1:0]  lane_idx_s [LANES];
    logic [W-1:0]   lane_in_s  [LANES];
    logic [W-1:0]   lane_tr_s  [LANES];
    logic [LW-1:0]  lane_mag_s [LANES];
    logic [SW-1:0]  tree_s;
    logic [XW-1:0]  acc_sum_s;
    logic           acc_ovf_s;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; the second DRAIN cycle hands over to DONE.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE:    if (start) state_next_s = RUN;   else state_next_s = IDLE;
            RUN:     if (beat_r == LAST_BEAT) state_next_s = DRAIN; else state_next_s = RUN;
            DRAIN:   if (drain_r) state_next_s = DONE; else state_next_s = DRAIN;
            DONE:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // Control decode from the current state.
    always_comb begin
        accept_s = 1'b0;
        issue_s  = 1'b0;
        finish_s = 1'b0;
        case (state_r)
            IDLE:    accept_s = start;
            RUN:     issue_s  = 1'b1;
            DRAIN:   issue_s  = 1'b0;
            DONE:    finish_s = 1'b1;
            default: finish_s = 1'b0;
        endcase
    end

    // Beat counter and drain-cycle marker.
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_r  <= '0;
            drain_r <= 1'b0;
        end else begin
            drain_r <= (state_r == DRAIN);
            if (accept_s) begin
                beat_r <= '0;
            end else if (issue_s && (beat_r != LAST_BEAT)) begin
                beat_r <= beat_r + 1'b1;
            end
        end
    end

    // Row-major feature selection for the current beat.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            lane_idx_s[l] = IW'(int'(beat_r) * LANES + l);
            lane_in_s[l]  = input_data[lane_idx_s[l]];
            lane_tr_s[l]  = training_data[lane_idx_s[l]];
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        distance_lane #(.W(W)) u_lane (
            .clk     (clk),
            .rst     (rst),
            .in_feat (lane_in_s[l]),
            .tr_feat (lane_tr_s[l]),
            .mode    (mode_r),
            .mag     (lane_mag_s[l])
        );
    end

    // Adder tree over the lanes plus the saturating accumulate candidate.
    always_comb begin
        tree_s = '0;
        for (int l = 0; l < LANES; l++) begin
            tree_s = tree_s + SW'(lane_mag_s[l]);
        end
        acc_sum_s = XW'(acc_r) + XW'(tree_s);
        if (acc_sum_s > XW'(DIST_MAX)) begin
            acc_ovf_s = 1'b1;
        end else begin
            acc_ovf_s = 1'b0;
        end
    end

    // Start capture, pipeline valids and the sticky-saturating accumulator.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_r     <= 1'b0;
            v2_r     <= 1'b0;
            acc_r    <= '0;
            sticky_r <= 1'b0;
            mode_r   <= MODE_SQ_EUCLID;
            label_r  <= '0;
        end else begin
            v1_r <= issue_s;
            v2_r <= v1_r;
            if (accept_s) begin
                acc_r    <= '0;
                sticky_r <= 1'b0;
                mode_r   <= mode_e'(mode);
                label_r  <= training_data_type;
            end else if (v2_r) begin
                if (acc_ovf_s) begin
                    acc_r    <= DIST_MAX;
                    sticky_r <= 1'b1;
                end else begin
                    acc_r <= acc_sum_s[DW-1:0];
                end
            end
        end
    end

    // Output registers; busy stays up through the cycle after DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy      <= 1'b0;
            done      <= 1'b0;
            distance  <= DIST_MAX;
            data_type <= '0;
            saturated <= 1'b0;
        end else begin
            busy <= (state_r != IDLE) || accept_s;
            done <= finish_s;
            if (finish_s) begin
                distance  <= acc_r;
                data_type <= label_r;
                saturated <= sticky_r;
            end
        end
    end

endmodule

// File: tb/tb_knn_distance_engine.sv
// Self-checking bench: table vectors, corner sequences and a random LANES sweep vs. a reference model.
module tb_knn_distance_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start;
    logic       mode;
    logic [7:0] label;
    logic [7:0] in_s [0:3];
    logic [7:0] tr_s [0:3];
    logic [7:0] in_l [0:15];
    logic [7:0] tr_l [0:15];

    logic        busy_a, done_a, sat_a;
    logic [19:0] dist_a;
    logic [7:0]  type_a;
    logic        busy_b, done_b, sat_b;
    logic [15:0] dist_b;
    logic [7:0]  type_b;
    logic        busy_l [3];
    logic        done_l [3];
    logic        sat_l  [3];
    logic [21:0] dist_l [3];
    logic [7:0]  type_l [3];

    knn_distance_engine #(.M(2), .N(2), .W(8), .LANES(2)) u_dut_a (
        .clk(clk), .rst(rst), .start(start), .mode(mode),
        .training_data(tr_s), .training_data_type(label), .input_data(in_s),
        .busy(busy_a), .distance(dist_a), .data_type(type_a),
        .saturated(sat_a), .done(done_a)
    );

    knn_distance_engine #(.M(2), .N(2), .W(8), .LANES(2), .DW(16)) u_dut_b (
        .clk(clk), .rst(rst), .start(start), .mode(mode),
        .training_data(tr_s), .training_data_type(label), .input_data(in_s),
        .busy(busy_b), .distance(dist_b), .data_type(type_b),
        .saturated(sat_b), .done(done_b)
    );

    for (genvar g = 0; g < 3; g++) begin : g_big
        knn_distance_engine #(.M(4), .N(4), .W(8), .LANES(1 << g)) u_dut (
            .clk(clk), .rst(rst), .start(start), .mode(mode),
            .training_data(tr_l), .training_data_type(label), .input_data(in_l),
            .busy(busy_l[g]), .distance(dist_l[g]), .data_type(type_l[g]),
            .saturated(sat_l[g]), .done(done_l[g])
        );
    end

    typedef struct {
        bit              mode;
        logic [7:0]      label;
        logic [3:0][7:0] in_v;
        logic [3:0][7:0] tr_v;
        int              exp_a;
        int              exp_b;
        bit              sat_b;
    } vec_t;

    localparam int NV = 6;
    vec_t tbl [NV];

    int checks = 0;
    int errors = 0;
    int done_cnt_a = 0;
    int k_a, k_b, c0, kd;
    int k_l [3];
    logic busy_a_6, busy_b_6;
    int q [$];
    logic [7:0] pa [16];
    logic [7:0] pb [16];
    longint s, mx;

    always @(posedge clk) begin
        if (done_a === 1'b1) done_cnt_a <= done_cnt_a + 1;
    end

    function automatic logic [3:0][7:0] pack4(input int a, input int b, input int c, input int d);
        logic [3:0][7:0] r;
        r[0] = 8'(a);
        r[1] = 8'(b);
        r[2] = 8'(c);
        r[3] = 8'(d);
        return r;
    endfunction

    // Unclamped distance over the first n features.
    function automatic longint ref_sum(input bit md, input int n, input logic [7:0] a [16], input logic [7:0] b [16]);
        longint acc;
        longint d;
        acc = 0;
        for (int i = 0; i < n; i++) begin
            d = longint'($signed(a[i])) - longint'($signed(b[i]));
            acc += md ? ((d < 0) ? -d : d) : d * d;
        end
        return acc;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic load_vec(input int t);
        mode  = tbl[t].mode;
        label = tbl[t].label;
        for (int i = 0; i < 4; i++) begin
            in_s[i] = tbl[t].in_v[i];
            tr_s[i] = tbl[t].tr_v[i];
        end
    endtask

    // Pulse start once and record the first done cycle of every instance (0 = none in 30 cycles).
    task automatic run_all();
        k_a = 0;
        k_b = 0;
        for (int g = 0; g < 3; g++) k_l[g] = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk); #1;
            if (done_a && k_a == 0) k_a = k;
            if (done_b && k_b == 0) k_b = k;
            for (int g = 0; g < 3; g++) begin
                if (done_l[g] && k_l[g] == 0) k_l[g] = k;
            end
            if (k == 6) begin
                busy_a_6 = busy_a;
                busy_b_6 = busy_b;
            end
        end
    endtask

    initial begin
        tbl[0] = '{1'b0, 8'd7,   pack4(3, -2, 5, 0),          pack4(1, 1, 5, -4),          29,     29,    1'b0};
        tbl[1] = '{1'b1, 8'd7,   pack4(3, -2, 5, 0),          pack4(1, 1, 5, -4),          9,      9,     1'b0};
        tbl[2] = '{1'b0, 8'd3,   pack4(-128, -128, -128, -128), pack4(127, 127, 127, 127), 260100, 65535, 1'b1};
        tbl[3] = '{1'b1, 8'd3,   pack4(-128, -128, -128, -128), pack4(127, 127, 127, 127), 1020,   1020,  1'b0};
        tbl[4] = '{1'b0, 8'd200, pack4(127, 127, -128, 0),    pack4(127, -128, 127, 0),    130050, 65535, 1'b1};
        tbl[5] = '{1'b1, 8'd255, pack4(-1, -1, -1, -1),       pack4(0, 0, 0, 0),           4,      4,     1'b0};

        rst   = 1'b1;
        start = 1'b0;
        mode  = 1'b0;
        label = 8'd0;
        for (int i = 0; i < 4; i++) begin
            in_s[i] = 8'd0;
            tr_s[i] = 8'd0;
        end
        for (int i = 0; i < 16; i++) begin
            in_l[i] = 8'd0;
            tr_l[i] = 8'd0;
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        chk("rst_dist_a", 64'(dist_a), 64'hFFFFF);
        chk("rst_dist_b", 64'(dist_b), 64'hFFFF);
        chk("rst_type_a", 64'(type_a), 64'd0);
        chk("rst_sat_a",  64'(sat_a),  64'd0);
        chk("rst_busy_a", 64'(busy_a), 64'd0);
        chk("rst_done_a", 64'(done_a), 64'd0);

        // Table vectors on the 2x2 instances (default DW and DW=16).
        for (int t = 0; t < NV; t++) begin
            load_vec(t);
            c0 = done_cnt_a;
            run_all();
            chk($sformatf("tbl%0d_lat_a", t),  64'(k_a), 64'd5);
            chk($sformatf("tbl%0d_lat_b", t),  64'(k_b), 64'd5);
            chk($sformatf("tbl%0d_dist_a", t), 64'(dist_a), 64'(tbl[t].exp_a));
            chk($sformatf("tbl%0d_type_a", t), 64'(type_a), 64'(tbl[t].label));
            chk($sformatf("tbl%0d_sat_a", t),  64'(sat_a), 64'd0);
            chk($sformatf("tbl%0d_dist_b", t), 64'(dist_b), 64'(tbl[t].exp_b));
            chk($sformatf("tbl%0d_sat_b", t),  64'(sat_b), 64'(tbl[t].sat_b));
            chk($sformatf("tbl%0d_type_b", t), 64'(type_b), 64'(tbl[t].label));
            chk($sformatf("tbl%0d_busy6", t),  64'({busy_a_6, busy_b_6}), 64'd0);
            chk($sformatf("tbl%0d_dones", t),  64'(done_cnt_a - c0), 64'd1);
        end

        // Back-to-back with start held high: second done six cycles after the first.
        load_vec(1);
        q.delete();
        start = 1'b1;
        @(posedge clk); #1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (k == 6) start = 1'b0;
            if (done_a) q.push_back(k);
        end
        chk("b2b_count", 64'(q.size()), 64'd2);
        chk("b2b_first", 64'((q.size() > 0) ? q[0] : 0), 64'd5);
        chk("b2b_second", 64'((q.size() > 1) ? q[1] : 0), 64'd11);
        chk("b2b_dist", 64'(dist_a), 64'd9);
        repeat (10) @(posedge clk); #1;

        // Start pulse with a new label and mode while busy is ignored.
        load_vec(0);
        c0 = done_cnt_a;
        kd = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (k == 2) begin
                start = 1'b1;
                mode  = 1'b1;
                label = 8'd99;
            end
            if (k == 3) start = 1'b0;
            if (done_a && kd == 0) kd = k;
        end
        chk("busy_pulse_dones", 64'(done_cnt_a - c0), 64'd1);
        chk("busy_pulse_lat", 64'(kd), 64'd5);
        chk("busy_pulse_dist", 64'(dist_a), 64'd29);
        chk("busy_pulse_type", 64'(type_a), 64'd7);
        repeat (10) @(posedge clk); #1;

        // Reset two cycles into RUN aborts without a done pulse.
        load_vec(0);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_busy", 64'(busy_a), 64'd0);
        chk("abort_done", 64'(done_a), 64'd0);
        chk("abort_dist_a", 64'(dist_a), 64'hFFFFF);
        chk("abort_type_a", 64'(type_a), 64'd0);
        chk("abort_dist_l0", 64'(dist_l[0]), 64'h3FFFFF);
        c0 = done_cnt_a;
        repeat (15) @(posedge clk); #1;
        chk("abort_no_done", 64'(done_cnt_a - c0), 64'd0);
        run_all();
        chk("after_abort_lat", 64'(k_a), 64'd5);
        chk("after_abort_dist", 64'(dist_a), 64'd29);

        // Random data on every instance against the reference model.
        for (int it = 0; it < 10; it++) begin
            mode  = 1'($urandom_range(0, 1));
            label = 8'($urandom);
            for (int i = 0; i < 16; i++) begin
                in_l[i] = 8'($urandom);
                tr_l[i] = 8'($urandom);
                pa[i]   = 8'd0;
                pb[i]   = 8'd0;
            end
            for (int i = 0; i < 4; i++) begin
                in_s[i] = 8'($urandom);
                tr_s[i] = 8'($urandom);
                pa[i]   = in_s[i];
                pb[i]   = tr_s[i];
            end
            run_all();
            s = ref_sum(mode, 4, pa, pb);
            chk($sformatf("rnd%0d_dist_a", it), 64'(dist_a), 64'(s));
            chk($sformatf("rnd%0d_lat_a", it), 64'(k_a), 64'd5);
            mx = 65535;
            chk($sformatf("rnd%0d_dist_b", it), 64'(dist_b), 64'((s > mx) ? mx : s));
            chk($sformatf("rnd%0d_sat_b", it), 64'(sat_b), 64'(s > mx));
            s = ref_sum(mode, 16, in_l, tr_l);
            for (int g = 0; g < 3; g++) begin
                chk($sformatf("rnd%0d_l%0d_lat", it, 1 << g),  64'(k_l[g]), 64'(16 / (1 << g) + 3));
                chk($sformatf("rnd%0d_l%0d_dist", it, 1 << g), 64'(dist_l[g]), 64'(s));
                chk($sformatf("rnd%0d_l%0d_type", it, 1 << g), 64'(type_l[g]), 64'(label));
                chk($sformatf("rnd%0d_l%0d_sat", it, 1 << g),  64'(sat_l[g]), 64'd0);
                chk($sformatf("rnd%0d_l%0d_busy", it, 1 << g), 64'(busy_l[g]), 64'd0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/knn_distance_engine.md
# knn_distance_engine

Parametrised, lane-parallel distance engine for the KNN classifier. It compares one query sample against one training sample, each M×N features, and returns either the squared-Euclidean or the Manhattan distance. It processes LANES features per cycle through a fixed pipeline. It sits between the training-memory sequencer and the k-nearest sorter, and forwards the training sample's class label alongside each distance.

## Interface
Parameters:
- M, 4, feature rows per sample.
- N, 4, feature columns per sample.
- W, 8, feature width in bits; features are signed two's complement.
- LANES, 2, features processed per cycle; must divide M*N (elaboration error otherwise).
- DW, 2*W+2+$clog2(M*N), distance/accumulator width; a smaller value is legal and enables saturation.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  request one distance computation; sampled only in IDLE.
- mode  in  1  0 = squared Euclidean, 1 = Manhattan; captured when start is accepted.
- training_data  in  W × (M*N)  training sample, unpacked array [0:M*N-1]; must stay stable while busy.
- training_data_type  in  W  class label; captured when start is accepted.
- input_data  in  W × (M*N)  query sample, unpacked array [0:M*N-1]; must stay stable while busy.
- busy  out  1  high in every state except IDLE.
- distance  out  DW  result, unsigned; held until the next done.
- data_type  out  W  label captured with the accepted start; updated together with distance.
- saturated  out  1  result was clipped to all-ones; updated together with distance.
- done  out  1  one-cycle pulse; distance, data_type and saturated are valid from this cycle on.

## Operation
- BEATS = M*N/LANES.
- States:
  - IDLE: waits for start.
  - RUN: issues BEATS beats.
  - DRAIN: 2 cycles to flush the pipeline.
  - DONE: 1 cycle, then returns to IDLE.
- Start handling:
  - start=1 in IDLE moves to RUN, clears the accumulator and sticky saturation flag, and captures mode and training_data_type.
  - start in RUN, DRAIN or DONE is ignored; it is not queued.
- Beat b (0..BEATS-1) covers feature indices b*LANES .. b*LANES+LANES-1, in row-major order (index i*N+j).
- Pipeline:
  - Stage 1, per lane: d = input − training, sign-extended to W+1 bits.
  - Stage 2, per lane: d*d (2W+2 bits) in mode 0, |d| (W+1 bits) in mode 1.
  - Stage 3: the adder tree sums all lanes, and the sum is added to the accumulator.
- Saturation: if any accumulate would exceed 2^DW−1, the accumulator clamps to all-ones and the sticky flag sets. With the default DW this cannot happen.
- DONE state: done=1, distance<=accumulator, data_type<=captured label, saturated<=sticky flag.
- Reset values: distance = all-ones, data_type = 0, saturated = 0, done = 0, busy = 0, state IDLE, accumulator 0.
- Reset mid-operation (any state) aborts: the state returns to IDLE, outputs take their reset values, and no done pulse is produced.

## Timing
- Let edge 0 be the edge that samples start=1 in IDLE. busy is high from edge 0 onward.
- Beats are issued at edges 1..BEATS. Stages 2 and 3 complete after 2 more edges. DONE is entered at edge BEATS+3.
- done is high for exactly one cycle, from edge BEATS+3 to edge BEATS+4. Latency from start to done is BEATS+3 cycles.
- busy falls at edge BEATS+4. A new start is accepted at edge BEATS+4 at the earliest, so throughput is one result per BEATS+4 cycles.
- Only mode and training_data_type are captured at edge 0. Changing training_data or input_data while busy gives an undefined result but does not hang the FSM.

## Structure
- Package knn_pkg holds:
  - state typedef: IDLE, RUN, DRAIN, DONE;
  - mode typedef: MODE_SQ_EUCLID, MODE_MANHATTAN;
  - localparam function computing the default DW;
  - reset-distance constant (all-ones).
- Sub-module distance_lane: one lane covering stages 1–2 (difference register, then square/abs register). It is instantiated LANES times via generate.
- The top level holds the beat counter, the FSM, the adder tree, the saturating accumulator and the output registers.

## Test plan
1. M=N=2, W=8, LANES=2, mode 0. input={3,−2,5,0}, training={1,1,5,−4}, label 7. Expect distance=29 (4+9+0+16) and data_type=7. done pulses once, 5 cycles after start. saturated=0.
2. Same data in mode 1: distance=9 (2+3+0+4). Run 1 back-to-back with start held high: start is ignored until IDLE, and the second result arrives 6 cycles after the first done.
3. Extremes, W=8: all input=−128, all training=127, mode 0. Expect distance=4*65025=260100, no saturation. Repeat with DW=16: distance=65535 and saturated=1.
4. Assert rst two cycles into RUN. Expect distance=all-ones, busy=0, no done pulse. A new start then gives a correct result.
5. Sweep LANES over {1,2,4} with M=N=4 and random data. Check against the reference model; latency must be BEATS+3 (19, 11, 7).
6. Pulse start while busy: no extra done, and the captured label and mode are unchanged.
